// File: rtl/bcd_pkg.sv
// Shared BCD digit types and helpers.
// Used by the digit counter and the 7-segment decoder bench.
package bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_MIN = 4'd0;

  function automatic logic is_bcd(bcd_t v);
    return (v <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_counter_if.sv
// Control and digit bundle of the BCD digit counter.
// Optional up_dn is present when BCD_UPDOWN_EN is defined.
interface bcd_digit_counter_if;
  import bcd_pkg::*;

  logic en;
  logic clr;
  logic load;
  bcd_t load_val;
`ifdef BCD_UPDOWN_EN
  logic up_dn;
`endif
  logic A;
  logic B;
  logic C;
  logic D;
  logic carry;

  modport master (
    output en, clr, load, load_val,
    input  A, B, C, D, carry
`ifdef BCD_UPDOWN_EN
    , output up_dn
`endif
  );

  modport slave (
    input  en, clr, load, load_val,
    output A, B, C, D, carry
`ifdef BCD_UPDOWN_EN
    , input up_dn
`endif
  );

endinterface

// File: rtl/tick_prescaler.sv
// Enable-gated prescaler: tick once every PRESCALE enabled cycles.
// Reusable by multi-digit scan logic.
module tick_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] r_pcnt;
  logic         w_last;

  assign w_last = (r_pcnt == LAST);
  assign tick   = en & w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
    end else if (clr) begin
      r_pcnt <= '0;
    end else if (en) begin
      r_pcnt <= w_last ? '0 : r_pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/bcd_digit_counter.sv
// Single BCD digit counter with prescaled stepping and wrap carry.
// Define BCD_UPDOWN_EN to add up/down counting via up_dn.
module bcd_digit_counter
  import bcd_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input logic                clk,
  input logic                rst_n,
  bcd_digit_counter_if.slave bus
);

  bcd_t r_digit;
  logic r_carry;
  logic w_tick;
  logic w_pclr;
  bcd_t w_next;
  logic w_wrap;
  bcd_t w_load;

  // load restarts the step period just like clr
  assign w_pclr = bus.clr | bus.load;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .clr   (w_pclr),
    .tick  (w_tick)
  );

  assign w_load = is_bcd(bus.load_val) ? bus.load_val : BCD_MIN;

  always_comb begin
    w_wrap = 1'b0;
    w_next = r_digit;
`ifdef BCD_UPDOWN_EN
    if (bus.up_dn) begin
      w_wrap = (r_digit >= BCD_MAX);
      w_next = w_wrap ? BCD_MIN : r_digit + 4'd1;
    end else begin
      w_wrap = (r_digit == BCD_MIN);
      w_next = w_wrap ? BCD_MAX : r_digit - 4'd1;
    end
`else
    w_wrap = (r_digit >= BCD_MAX);
    w_next = w_wrap ? BCD_MIN : r_digit + 4'd1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit <= BCD_MIN;
      r_carry <= 1'b0;
    end else if (bus.clr) begin
      r_digit <= BCD_MIN;
      r_carry <= 1'b0;
    end else if (bus.load) begin
      r_digit <= w_load;
      r_carry <= 1'b0;
    end else if (w_tick) begin
      r_digit <= w_next;
      r_carry <= w_wrap;
    end else begin
      r_carry <= 1'b0;
    end
  end

  assign bus.A     = r_digit[3];
  assign bus.B     = r_digit[2];
  assign bus.C     = r_digit[1];
  assign bus.D     = r_digit[0];
  assign bus.carry = r_carry;

endmodule

// File: tb/tb_bcd_digit_counter.sv
// Directed bench for bcd_digit_counter (PRESCALE=4).
// Exercises the up/down path when BCD_UPDOWN_EN is defined.
module tb_bcd_digit_counter;
  import bcd_pkg::*;

  typedef struct {
    logic       en;
    logic       clr;
    logic       load;
    logic [3:0] val;
    logic [3:0] d;
    logic       c;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  vec_t vq[$];

  bcd_digit_counter_if bus ();

  bcd_digit_counter #(
    .PRESCALE (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [3:0] ed, logic ec);
    logic [3:0] d;
    d = {bus.A, bus.B, bus.C, bus.D};
    n_chk++;
    if (d !== ed) begin
      n_fail++;
      $display("FAIL %s digit got %0d want %0d", nm, d, ed);
    end
    n_chk++;
    if (bus.carry !== ec) begin
      n_fail++;
      $display("FAIL %s carry got %b want %b", nm, bus.carry, ec);
    end
    n_chk++;
    if (!is_bcd(d)) begin
      n_fail++;
      $display("FAIL %s bcd range got %0d want <=9", nm, d);
    end
  endtask

  task automatic drv(logic en, logic clr, logic load, logic [3:0] v);
    bus.en       = en;
    bus.clr      = clr;
    bus.load     = load;
    bus.load_val = v;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    drv(0, 0, 0, 4'd0);
`ifdef BCD_UPDOWN_EN
    bus.up_dn = 1'b1;
`endif
    #3;
    chk("reset", 4'd0, 1'b0);
    #9;
    rst_n = 1'b1;

    // {en, clr, load, val, exp digit, exp carry}
    vq.push_back('{0, 0, 1, 4'd7,  4'd7, 0});
    vq.push_back('{1, 0, 0, 4'd0,  4'd7, 0});
    vq.push_back('{1, 0, 0, 4'd0,  4'd7, 0});
    vq.push_back('{1, 0, 0, 4'd0,  4'd7, 0});
    vq.push_back('{1, 0, 0, 4'd0,  4'd8, 0});
    vq.push_back('{0, 0, 1, 4'd12, 4'd0, 0});
    vq.push_back('{1, 0, 0, 4'd0,  4'd0, 0});
    vq.push_back('{1, 0, 0, 4'd0,  4'd0, 0});
    vq.push_back('{1, 0, 0, 4'd0,  4'd0, 0});
    vq.push_back('{1, 0, 0, 4'd0,  4'd1, 0});
    vq.push_back('{0, 0, 1, 4'd9,  4'd9, 0});
    vq.push_back('{1, 0, 0, 4'd0,  4'd9, 0});
    vq.push_back('{1, 0, 0, 4'd0,  4'd9, 0});
    vq.push_back('{1, 0, 0, 4'd0,  4'd9, 0});
    vq.push_back('{1, 0, 0, 4'd0,  4'd0, 1});
    vq.push_back('{0, 0, 0, 4'd0,  4'd0, 0});
    vq.push_back('{0, 0, 1, 4'd9,  4'd9, 0});
    vq.push_back('{1, 0, 0, 4'd0,  4'd9, 0});
    vq.push_back('{1, 0, 0, 4'd0,  4'd9, 0});
    vq.push_back('{1, 0, 0, 4'd0,  4'd9, 0});
    vq.push_back('{1, 1, 1, 4'd5,  4'd0, 0});
    vq.push_back('{1, 0, 0, 4'd0,  4'd0, 0});
    vq.push_back('{1, 0, 0, 4'd0,  4'd0, 0});
    vq.push_back('{1, 0, 0, 4'd0,  4'd0, 0});
    vq.push_back('{1, 0, 0, 4'd0,  4'd1, 0});
    vq.push_back('{1, 0, 1, 4'd15, 4'd0, 0});
    vq.push_back('{0, 0, 1, 4'd5,  4'd5, 0});

    foreach (vq[i]) begin
      drv(vq[i].en, vq[i].clr, vq[i].load, vq[i].val);
      cyc();
      chk($sformatf("vec%0d", i), vq[i].d, vq[i].c);
    end

    // 40 enabled cycles: one step per 4 clocks, one wrap
    begin
      int ncar;
      logic [3:0] ed;
      ncar = 0;
      drv(0, 1, 0, 4'd0);
      cyc();
      chk("cnt_clr", 4'd0, 1'b0);
      drv(1, 0, 0, 4'd0);
      for (int k = 1; k <= 40; k++) begin
        cyc();
        ed = 4'((k / 4) % 10);
        if (bus.carry === 1'b1) ncar++;
        chk($sformatf("cnt%0d", k), ed, (k % 4 == 0) && (ed == 4'd0));
      end
      n_chk++;
      if (ncar != 1) begin
        n_fail++;
        $display("FAIL cnt_carry_pulses got %0d want 1", ncar);
      end
    end

    // en gap at pcnt=2
    drv(0, 1, 0, 4'd0);
    cyc();
    drv(1, 0, 0, 4'd0);
    cyc();
    cyc();
    drv(0, 0, 0, 4'd0);
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk($sformatf("gap%0d", k), 4'd0, 1'b0);
    end
    drv(1, 0, 0, 4'd0);
    cyc();
    chk("gap_res1", 4'd0, 1'b0);
    cyc();
    chk("gap_res2", 4'd1, 1'b0);

    // async reset mid-count at digit 6
    drv(0, 0, 1, 4'd6);
    cyc();
    drv(1, 0, 0, 4'd0);
    cyc();
    cyc();
    chk("pre_rst", 4'd6, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_rst", 4'd0, 1'b0);
    #2;
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk($sformatf("post_rst%0d", k), (k == 4) ? 4'd1 : 4'd0, 1'b0);
    end

`ifdef BCD_UPDOWN_EN
    drv(0, 1, 0, 4'd0);
    bus.up_dn = 1'b0;
    cyc();
    drv(1, 0, 0, 4'd0);
    for (int k = 1; k <= 12; k++) begin
      logic [3:0] ed;
      cyc();
      ed = (k < 4) ? 4'd0 : (k < 8) ? 4'd9 : (k < 12) ? 4'd8 : 4'd7;
      chk($sformatf("down%0d", k), ed, k == 4);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
